// File: rtl/systolic_pe_stream_pkg.sv
// ============================================================================
// Package  : systolic_pkg
// Brief    : Shared types, default widths and width helper for the systolic PE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package systolic_pkg;

    localparam int c_DEFAULT_DATA_WIDTH = 10;
    localparam int c_DEFAULT_ACC_WIDTH  = 28;

    typedef enum logic [0:0] {
        PE_IDLE = 1'b0,
        PE_ACC  = 1'b1
    } pe_state_t;

    function automatic int acc_width_min(input int data_width);
        return 2 * data_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_pe_stream_if.sv
// ============================================================================
// Interface : systolic_pe_stream_if
// Brief     : Operand/forwarding/result bundle of one systolic PE.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface systolic_pe_stream_if #(
    parameter int DATA_WIDTH = systolic_pkg::c_DEFAULT_DATA_WIDTH,
    parameter int ACC_WIDTH  = systolic_pkg::c_DEFAULT_ACC_WIDTH
) ();

    logic                  mode_signed;
    logic [DATA_WIDTH-1:0] a_in;
    logic                  a_valid_in;
    logic                  a_last_in;
    logic [DATA_WIDTH-1:0] b_in;
    logic                  b_valid_in;
    logic [DATA_WIDTH-1:0] a_out;
    logic                  a_valid_out;
    logic                  a_last_out;
    logic [DATA_WIDTH-1:0] b_out;
    logic                  b_valid_out;
    logic [ACC_WIDTH-1:0]  res_out;
    logic                  res_valid;
    logic                  busy;
    logic                  err_mismatch;
    logic                  ovf;

    modport master (
        output mode_signed, a_in, a_valid_in, a_last_in, b_in, b_valid_in,
        input  a_out, a_valid_out, a_last_out, b_out, b_valid_out,
        input  res_out, res_valid, busy, err_mismatch, ovf
    );

    modport slave (
        input  mode_signed, a_in, a_valid_in, a_last_in, b_in, b_valid_in,
        output a_out, a_valid_out, a_last_out, b_out, b_valid_out,
        output res_out, res_valid, busy, err_mismatch, ovf
    );

endinterface

`default_nettype wire

// File: rtl/systolic_pe_stream_mul_pipe.sv
// ============================================================================
// Module   : pe_mul_pipe
// Brief    : MUL_STAGES-deep signed/unsigned multiplier carrying valid/last/mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_mul_pipe
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int MUL_STAGES = 2
) (
    input  wire logic                                clk,
    input  wire logic                                rst,
    input  wire logic                                i_valid,
    input  wire logic                                i_last,
    input  wire logic                                i_signed,
    input  wire logic [DATA_WIDTH-1:0]               i_a,
    input  wire logic [DATA_WIDTH-1:0]               i_b,
    output logic                                     o_valid,
    output logic                                     o_last,
    output logic                                     o_signed,
    output logic [acc_width_min(DATA_WIDTH)-1:0]     o_prod,
    output logic                                     o_any_valid
);

    localparam int c_PROD_WIDTH = acc_width_min(DATA_WIDTH);

    logic [c_PROD_WIDTH-1:0] w_a_ext;
    logic [c_PROD_WIDTH-1:0] w_b_ext;
    logic [c_PROD_WIDTH-1:0] w_prod;

    logic [MUL_STAGES-1:0]   r_valid;
    logic [MUL_STAGES-1:0]   r_last;
    logic [MUL_STAGES-1:0]   r_signed;
    logic [c_PROD_WIDTH-1:0] r_prod [MUL_STAGES];

    // Extending both operands to the full product width makes the low
    // product bits correct for either signedness.
    assign w_a_ext = {{DATA_WIDTH{i_signed & i_a[DATA_WIDTH-1]}}, i_a};
    assign w_b_ext = {{DATA_WIDTH{i_signed & i_b[DATA_WIDTH-1]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= '0;
            r_last   <= '0;
            r_signed <= '0;
            for (int i = 0; i < MUL_STAGES; i++) begin
                r_prod[i] <= '0;
            end
        end else begin
            r_valid[0]  <= i_valid;
            r_last[0]   <= i_valid & i_last;
            r_signed[0] <= i_signed;
            r_prod[0]   <= i_valid ? w_prod : '0;
            for (int i = 1; i < MUL_STAGES; i++) begin
                r_valid[i]  <= r_valid[i-1];
                r_last[i]   <= r_last[i-1];
                r_signed[i] <= r_signed[i-1];
                r_prod[i]   <= r_prod[i-1];
            end
        end
    end

    assign o_valid     = r_valid[MUL_STAGES-1];
    assign o_last      = r_last[MUL_STAGES-1];
    assign o_signed    = r_signed[MUL_STAGES-1];
    assign o_prod      = r_prod[MUL_STAGES-1];
    assign o_any_valid = |r_valid;

endmodule

`default_nettype wire

// File: rtl/systolic_pe_stream.sv
// ============================================================================
// Module   : systolic_pe_stream
// Brief    : Output-stationary systolic PE: operand forwarding, pipelined MAC,
//            last-delimited tiles. Option macro: SYSTOLIC_PE_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_pe_stream
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int ACC_WIDTH  = c_DEFAULT_ACC_WIDTH,
    parameter int MUL_STAGES = 2
) (
    input wire logic             clk,
    input wire logic             rst,
    systolic_pe_stream_if.slave  pe
);

    localparam int c_PROD_WIDTH = acc_width_min(DATA_WIDTH);

    logic [DATA_WIDTH-1:0]   r_a_out;
    logic                    r_a_valid;
    logic                    r_a_last;
    logic [DATA_WIDTH-1:0]   r_b_out;
    logic                    r_b_valid;

    pe_state_t               r_state;
    logic [ACC_WIDTH-1:0]    r_acc;
    logic [ACC_WIDTH-1:0]    r_res;
    logic                    r_res_valid;
    logic                    r_err;
    logic                    r_ovf;

    logic                    w_accept;
    logic                    w_mismatch;
    logic                    w_mul_valid;
    logic                    w_mul_last;
    logic                    w_mul_signed;
    logic [c_PROD_WIDTH-1:0] w_mul_prod;
    logic                    w_mul_any;
    logic [ACC_WIDTH-1:0]    w_prod_ext;
    logic [ACC_WIDTH-1:0]    w_acc_cur;
    logic [ACC_WIDTH:0]      w_sum;
    logic                    w_ovf;
    logic [ACC_WIDTH-1:0]    w_next;

    assign w_accept   = pe.a_valid_in & pe.b_valid_in;
    assign w_mismatch = pe.a_valid_in ^ pe.b_valid_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_out   <= '0;
            r_a_valid <= 1'b0;
            r_a_last  <= 1'b0;
            r_b_out   <= '0;
            r_b_valid <= 1'b0;
        end else begin
            r_a_out   <= pe.a_valid_in ? pe.a_in : '0;
            r_a_valid <= pe.a_valid_in;
            r_a_last  <= pe.a_last_in;
            r_b_out   <= pe.b_valid_in ? pe.b_in : '0;
            r_b_valid <= pe.b_valid_in;
        end
    end

    pe_mul_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .MUL_STAGES (MUL_STAGES)
    ) u_mul (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (w_accept),
        .i_last      (pe.a_last_in),
        .i_signed    (pe.mode_signed),
        .i_a         (pe.a_in),
        .i_b         (pe.b_in),
        .o_valid     (w_mul_valid),
        .o_last      (w_mul_last),
        .o_signed    (w_mul_signed),
        .o_prod      (w_mul_prod),
        .o_any_valid (w_mul_any)
    );

    if (ACC_WIDTH > c_PROD_WIDTH) begin : g_ext
        assign w_prod_ext = {{(ACC_WIDTH-c_PROD_WIDTH){w_mul_signed & w_mul_prod[c_PROD_WIDTH-1]}},
                             w_mul_prod};
    end else begin : g_noext
        assign w_prod_ext = w_mul_prod[ACC_WIDTH-1:0];
    end

    // A product arriving in IDLE starts a fresh tile, so it adds to zero.
    assign w_acc_cur = (r_state == PE_ACC) ? r_acc : '0;
    assign w_sum     = {1'b0, w_acc_cur} + {1'b0, w_prod_ext};

    always_comb begin
        w_ovf = w_sum[ACC_WIDTH];
        if (w_mul_signed) begin
            w_ovf = (w_acc_cur[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1]) &&
                    (w_sum[ACC_WIDTH-1] != w_acc_cur[ACC_WIDTH-1]);
        end
    end

`ifdef SYSTOLIC_PE_SATURATE_EN
    localparam logic [ACC_WIDTH-1:0] c_MAX_POS = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] c_MIN_NEG = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    always_comb begin
        w_next = w_sum[ACC_WIDTH-1:0];
        if (w_ovf) begin
            if (w_mul_signed) begin
                w_next = w_acc_cur[ACC_WIDTH-1] ? c_MIN_NEG : c_MAX_POS;
            end else begin
                w_next = '1;
            end
        end
    end
`else
    assign w_next = w_sum[ACC_WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= PE_IDLE;
            r_acc       <= '0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_err       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            if (w_mismatch) begin
                r_err <= 1'b1;
            end
            if (w_mul_valid) begin
                r_ovf <= ((r_state == PE_IDLE) ? 1'b0 : r_ovf) | w_ovf;
                if (w_mul_last) begin
                    r_res       <= w_next;
                    r_res_valid <= 1'b1;
                    r_acc       <= '0;
                    r_state     <= PE_IDLE;
                end else begin
                    r_acc   <= w_next;
                    r_state <= PE_ACC;
                end
            end
        end
    end

    assign pe.a_out        = r_a_out;
    assign pe.a_valid_out  = r_a_valid;
    assign pe.a_last_out   = r_a_last;
    assign pe.b_out        = r_b_out;
    assign pe.b_valid_out  = r_b_valid;
    assign pe.res_out      = r_res;
    assign pe.res_valid    = r_res_valid;
    assign pe.busy         = (r_state == PE_ACC) | w_mul_any;
    assign pe.err_mismatch = r_err;
    assign pe.ovf          = r_ovf;

endmodule

`default_nettype wire
